// File: rtl/pixel_stream_packer.sv
// Packs 16-bit pixel pairs into 32-bit AXI4-Stream words with frame/line markers and a FWFT output FIFO.
// Optional counters are enabled by defining PIXEL_STREAM_PACKER_STATS_EN.
module pixel_stream_packer #(
    parameter int C_PIXEL_DATA_WIDTH = 16,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH       = 16,
    parameter int C_LINE_PIXELS      = 640
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [C_PIXEL_DATA_WIDTH-1:0] pixel_data,
    input  logic                          pixel_valid,
    input  logic                          pixel_sof,
    input  logic                          pixel_eol,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          status_clear,
    output logic                          overflow,
    output logic                          line_err,
    output logic                          busy
`ifdef PIXEL_STREAM_PACKER_STATS_EN
    ,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   drop_count
`endif
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam logic [15:0] LINE_LEN = 16'(C_LINE_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    state_t                          state_r;
    logic [C_PIXEL_DATA_WIDTH-1:0]   half_r;
    logic                            half_valid_r;
    logic                            first_r;
    logic [15:0]                     pix_cnt_r;
    logic [15:0]                     line_total_s;
    logic                            stage_valid_r;
    logic [C_AXIS_TDATA_WIDTH-1:0]   stage_data_r;
    logic                            stage_last_r;
    logic                            stage_user_r;
    logic                            overflow_r;
    logic                            line_err_r;

    logic [C_AXIS_TDATA_WIDTH+1:0]   fifo_mem [C_FIFO_DEPTH];
    logic [AW-1:0]                   wr_ptr_r;
    logic [AW-1:0]                   rd_ptr_r;
    logic [AW:0]                     fifo_count_r;
    logic                            fifo_full_s;
    logic                            fifo_empty_s;
    logic                            rd_fire_s;
    logic                            wr_fire_s;
    logic                            ovf_event_s;
    logic                            sof_in_s;
    logic [C_AXIS_TDATA_WIDTH+1:0]   rd_word_s;

    assign fifo_full_s  = (fifo_count_r == (AW+1)'(C_FIFO_DEPTH));
    assign fifo_empty_s = (fifo_count_r == '0);
    assign rd_fire_s    = !fifo_empty_s && m_axis_tready;
    // A full FIFO still accepts the staged word when a read frees a slot in the same cycle.
    assign wr_fire_s    = stage_valid_r && (!fifo_full_s || rd_fire_s);
    assign ovf_event_s  = stage_valid_r && fifo_full_s && !rd_fire_s;
    assign sof_in_s     = pixel_valid && pixel_sof;
    assign line_total_s = pix_cnt_r + 16'd1;
    assign rd_word_s    = fifo_mem[rd_ptr_r];

    // Packing FSM, line-length check, word staging register and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            half_r        <= '0;
            half_valid_r  <= 1'b0;
            first_r       <= 1'b0;
            pix_cnt_r     <= 16'd0;
            stage_valid_r <= 1'b0;
            stage_data_r  <= '0;
            stage_last_r  <= 1'b0;
            stage_user_r  <= 1'b0;
            overflow_r    <= 1'b0;
            line_err_r    <= 1'b0;
        end else begin
            stage_valid_r <= 1'b0;
            if (status_clear) begin
                overflow_r <= 1'b0;
                line_err_r <= 1'b0;
            end
            if (ovf_event_s) begin
                overflow_r <= 1'b1;
            end
            if (sof_in_s) begin
                if (state_r == S_ACTIVE && half_valid_r) begin
                    line_err_r <= 1'b1;
                end
                half_valid_r <= 1'b0;
                if (enable) begin
                    state_r <= S_ACTIVE;
                    if (pixel_eol) begin
                        // One-pixel line: padded word, and the length can never match an even line.
                        stage_valid_r <= 1'b1;
                        stage_data_r  <= {{C_PIXEL_DATA_WIDTH{1'b0}}, pixel_data};
                        stage_last_r  <= 1'b1;
                        stage_user_r  <= 1'b1;
                        first_r       <= 1'b0;
                        pix_cnt_r     <= 16'd0;
                        line_err_r    <= 1'b1;
                    end else begin
                        half_r       <= pixel_data;
                        half_valid_r <= 1'b1;
                        first_r      <= 1'b1;
                        pix_cnt_r    <= 16'd1;
                    end
                end else begin
                    state_r   <= S_IDLE;
                    first_r   <= 1'b0;
                    pix_cnt_r <= 16'd0;
                end
            end else if (state_r == S_ACTIVE) begin
                if (ovf_event_s) begin
                    state_r      <= S_DROP;
                    half_valid_r <= 1'b0;
                end else if (pixel_valid) begin
                    if (half_valid_r || pixel_eol) begin
                        stage_valid_r <= 1'b1;
                        stage_data_r  <= half_valid_r ? {pixel_data, half_r}
                                                      : {{C_PIXEL_DATA_WIDTH{1'b0}}, pixel_data};
                        stage_last_r  <= pixel_eol;
                        stage_user_r  <= first_r;
                        first_r       <= 1'b0;
                        half_valid_r  <= 1'b0;
                        if (!half_valid_r) begin
                            line_err_r <= 1'b1;
                        end
                    end else begin
                        half_r       <= pixel_data;
                        half_valid_r <= 1'b1;
                    end
                    if (pixel_eol) begin
                        pix_cnt_r <= 16'd0;
                        if (line_total_s != LINE_LEN) begin
                            line_err_r <= 1'b1;
                        end
                    end else if (pix_cnt_r != 16'hFFFF) begin
                        pix_cnt_r <= line_total_s;
                    end
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_fire_s, rd_fire_s})
                2'b10:   fifo_count_r <= fifo_count_r + 1'b1;
                2'b01:   fifo_count_r <= fifo_count_r - 1'b1;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage; entries are {last, user, data}.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            fifo_mem[wr_ptr_r] <= {stage_last_r, stage_user_r, stage_data_r};
        end
    end

    // First-word-fall-through read side; outputs forced to zero while empty.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        m_axis_tuser = 1'b0;
        if (fifo_empty_s) begin
            m_axis_tdata = '0;
            m_axis_tlast = 1'b0;
            m_axis_tuser = 1'b0;
        end else begin
            m_axis_tdata = rd_word_s[C_AXIS_TDATA_WIDTH-1:0];
            m_axis_tuser = rd_word_s[C_AXIS_TDATA_WIDTH];
            m_axis_tlast = rd_word_s[C_AXIS_TDATA_WIDTH+1];
        end
    end

    assign m_axis_tvalid = !fifo_empty_s;
    assign overflow      = overflow_r;
    assign line_err      = line_err_r;
    assign busy          = (state_r != S_IDLE) || !fifo_empty_s || stage_valid_r;

`ifdef PIXEL_STREAM_PACKER_STATS_EN
    logic [15:0] frame_count_r;
    logic [15:0] drop_count_r;
    logic        frame_event_s;
    logic        drop_event_s;

    assign frame_event_s = sof_in_s && enable;
    assign drop_event_s  = (state_r == S_ACTIVE) && ovf_event_s && !sof_in_s;

    // Frame and drop counters; an increment wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_r <= 16'd0;
            drop_count_r  <= 16'd0;
        end else begin
            if (frame_event_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else if (status_clear) begin
                frame_count_r <= 16'd0;
            end
            if (drop_event_s) begin
                drop_count_r <= drop_count_r + 16'd1;
            end else if (status_clear) begin
                drop_count_r <= 16'd0;
            end
        end
    end

    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;
`endif

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
Downstream stage of the image processor in the capture_video IP. Takes processed 16-bit pixels (one per clock when valid, no backpressure possible) and packs pixel pairs into 32-bit AXI4-Stream words. Adds frame (tuser) and line (tlast) markers, and buffers words in a small FIFO so the VDMA can stall briefly. Reports overflow and line-length errors as sticky status bits for the AXI register bank.

Parameters:
C_PIXEL_DATA_WIDTH, 16, pixel width; fixed at 16, two pixels per word
C_AXIS_TDATA_WIDTH, 32, output stream width; must equal 2*C_PIXEL_DATA_WIDTH
C_FIFO_DEPTH, 16, output FIFO depth in words; power of two, >=4
C_LINE_PIXELS, 640, expected pixels per line, used by the length check

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
enable  in  1  capture enable (control register bit 0); sampled only at frame start
pixel_data  in  16  processed pixel from image processor
pixel_valid  in  1  pixel_data valid this cycle
pixel_sof  in  1  with pixel_valid: first pixel of frame
pixel_eol  in  1  with pixel_valid: last pixel of line
m_axis_tdata  out  32  packed word; first pixel [15:0], second pixel [31:16]
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  word holds last pixel of a line
m_axis_tuser  out  1  first word of a frame
status_clear  in  1  single-cycle pulse; clears overflow and line_err
overflow  out  1  sticky: a word was dropped because the FIFO was full
line_err  out  1  sticky: line length differed from C_LINE_PIXELS
busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset: all outputs 0. FIFO flushed, FSM to IDLE, pixel counter and half-word register cleared. Reset mid-frame discards all buffered data; m_axis_tvalid is 0 in the cycle after rst is sampled high.
- FSM states:
  - IDLE: wait for pixel_valid&&pixel_sof. If enable=1, go to ACTIVE and that pixel is packed as the low half of the first word. If enable=0, stay in IDLE and ignore the frame.
  - ACTIVE: pack pixels. A word completes on every second pixel, or on pixel_eol with only the low half filled; the upper half is then zero-padded and line_err is set, since C_LINE_PIXELS is even. A FIFO write attempt on a full FIFO sets overflow, drops the word and moves to DROP.
  - DROP: ignore pixels until the next pixel_valid&&pixel_sof, then handle it as in IDLE.
- pixel_sof in ACTIVE with a pending half-word: discard the half-word, set line_err, restart the frame with this pixel.
- Word markers:
  - tuser=1 on the first word written after frame start only.
  - tlast=1 on the word completed by pixel_eol.
- Line length check: pixel counter reset at each sof/eol. At eol, count (including the eol pixel) != C_LINE_PIXELS sets line_err.
- FIFO:
  - Entries 34 bits (data, last, user).
  - Write when full is accepted if a read (tvalid&&tready) occurs in the same cycle.
  - Read side is first-word-fall-through.
  - tvalid/tdata/tlast/tuser are stable while tvalid&&!tready.
- Latency: the completing pixel is presented in cycle N. The word is written at the end of cycle N+1 and m_axis_tvalid is high in cycle N+2 when the FIFO was empty.
- Sticky bits: set has priority over a simultaneous status_clear.
- enable dropping mid-frame has no effect until the next sof.

Optional Feature:
PIXEL_STREAM_PACKER_STATS_EN.
- Defined: adds outputs frame_count[15:0] and drop_count[15:0].
  - frame_count increments on each frame accepted into ACTIVE.
  - drop_count increments on each transition into DROP.
  - Both wrap at 16'hFFFF->0, are cleared by rst and status_clear, and increment has priority over clear.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Line of 640 pixels, values 0..639, tready=1, sof on pixel 0, eol on pixel 639 -> 320 words. Word0 = 32'h0001_0000 with tuser=1. Word319 = 32'h027F_027E with tlast=1. overflow=0, line_err=0.
2. Same line with tready=0 throughout, C_FIFO_DEPTH=16 -> 16 words buffered; 17th dropped; overflow=1; FSM in DROP. After next sof with tready=1, the new frame streams with tuser=1 on its first word.
3. Line of 3 pixels A,B,C (eol on C) -> words {B,A} tlast=0 and {16'h0000,C} tlast=1; line_err=1. status_clear pulse -> line_err=0.
4. enable=0 at sof, 640 pixels presented -> no tvalid. enable=1 at next sof -> frame streams normally.
5. Assert rst for 1 cycle after 100 pixels with 5 words buffered -> tvalid=0 next cycle, FIFO empty, busy=0. A subsequent frame starts cleanly with tuser=1.
6. tready toggling 1/0 each cycle over a full line -> no data loss, all 320 words in order, tdata stable while stalled.
